// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone arbiter family: grant encoding and bus width defaults.
package wb_arb_pkg;

   localparam int ADR_W_DEF = 19;
   localparam int DAT_W_DEF = 16;
   localparam int SEL_W_DEF = 2;

   // Grant states are one-hot so the state register doubles as the gnt_o bus.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_G0   = 2'b01,
      ST_G1   = 2'b10
   } gnt_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational 2-way picker: fixed priority (req[0] wins) or round-robin (last owner loses ties).
module wb_arb_pick #(
   parameter bit RR = 1'b0
) (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         pick = (RR && !last) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone arbiter with bus lock on cyc and a hold limit that forces
// handoff when the other master has been waiting for MAX_HOLD acked transfers.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no owner, slave request lines held low
// ST_G0   | master 0 owns the slave until it drops cyc or the hold limit hits
// ST_G1   | master 1 owns the slave until it drops cyc or the hold limit hits
module wb_arb2
   import wb_arb_pkg::*;
#(
   parameter int ADR_W    = ADR_W_DEF,
   parameter int DAT_W    = DAT_W_DEF,
   parameter int SEL_W    = SEL_W_DEF,
   parameter bit RR       = 1'b0,
   parameter int MAX_HOLD = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [DAT_W-1:0] m0_dat_i,
   input  logic [SEL_W-1:0] m0_sel_i,
   input  logic             m0_we_i,
   input  logic             m0_stb_i,
   input  logic             m0_cyc_i,
   output logic [DAT_W-1:0] m0_dat_o,
   output logic             m0_ack_o,
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [DAT_W-1:0] m1_dat_i,
   input  logic [SEL_W-1:0] m1_sel_i,
   input  logic             m1_we_i,
   input  logic             m1_stb_i,
   input  logic             m1_cyc_i,
   output logic [DAT_W-1:0] m1_dat_o,
   output logic             m1_ack_o,
   output logic [ADR_W-1:0] s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   output logic [SEL_W-1:0] s_sel_o,
   output logic             s_we_o,
   output logic             s_stb_o,
   output logic             s_cyc_o,
   input  logic [DAT_W-1:0] s_dat_i,
   input  logic             s_ack_i,
   output logic [1:0]       gnt_o
);

   gnt_t       gnt, gnt_nxt;
   logic       last, last_nxt;
   logic [7:0] hcnt, hcnt_nxt;
   logic       req0, req1;
   logic       own0, own1;
   logic       own_cyc;
   logic       other_req;
   logic       brk;
   logic       xfer_ack;
   logic [1:0] pick;

   assign req0      = m0_cyc_i & m0_stb_i;
   assign req1      = m1_cyc_i & m1_stb_i;
   assign own0      = (gnt == ST_G0);
   assign own1      = (gnt == ST_G1);
   assign own_cyc   = own0 ? m0_cyc_i : m1_cyc_i;
   assign other_req = (own0 & req1) | (own1 & req0);
   assign brk       = other_req && (hcnt == 8'(MAX_HOLD));

   wb_arb_pick #(.RR(RR)) u_pick (
      .req  ({req1, req0}),
      .last (last),
      .pick (pick)
   );

   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_stb_o = 1'b0;
      s_cyc_o = 1'b0;
      if (own0) begin
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_sel_o = m0_sel_i;
         s_we_o  = m0_we_i;
         s_cyc_o = m0_cyc_i;
         s_stb_o = m0_stb_i & !brk;
      end else if (own1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_sel_o = m1_sel_i;
         s_we_o  = m1_we_i;
         s_cyc_o = m1_cyc_i;
         s_stb_o = m1_stb_i & !brk;
      end
   end

   // Acks are qualified by the (possibly masked) strobe so stray slave acks never reach a master.
   assign xfer_ack = s_ack_i & s_stb_o;
   assign m0_ack_o = own0 & xfer_ack;
   assign m1_ack_o = own1 & xfer_ack;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign gnt_o    = gnt;

   always_comb begin
      gnt_nxt  = gnt;
      last_nxt = last;
      hcnt_nxt = hcnt;
      case (gnt)
         ST_IDLE: begin
            hcnt_nxt = '0;
            // pick is one-hot or zero, matching the grant encoding bit for bit
            gnt_nxt  = gnt_t'(pick);
         end
         ST_G0, ST_G1: begin
            if (!own_cyc || brk) begin
               gnt_nxt  = other_req ? (own0 ? ST_G1 : ST_G0) : ST_IDLE;
               last_nxt = own1;
               hcnt_nxt = '0;
            end else if (!other_req) begin
               hcnt_nxt = '0;
            end else if (xfer_ack) begin
               hcnt_nxt = hcnt + 8'd1;
            end
         end
         default: begin
            gnt_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         gnt  <= ST_IDLE;
         last <= 1'b1;
         hcnt <= '0;
      end else begin
         gnt  <= gnt_nxt;
         last <= last_nxt;
         hcnt <= hcnt_nxt;
      end
   end

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2: two instances (fixed priority and round-robin, both MAX_HOLD=4), each with
// a registered-ack slave model; per-master expectation queues are drained by a monitor on acks.
module tb_wb_arb2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [18:0] m_adr  [4];
   logic [15:0] m_dat  [4];
   logic [1:0]  m_sel  [4];
   logic        m_we   [4];
   logic        m_stb  [4];
   logic        m_cyc  [4];
   logic [15:0] m_rdat [4];
   logic        m_ack  [4];

   logic [18:0] s_adr  [2];
   logic [15:0] s_wdat [2];
   logic [15:0] s_rdat [2];
   logic [1:0]  s_sel  [2];
   logic        s_we   [2];
   logic        s_stb  [2];
   logic        s_cyc  [2];
   logic        s_ack  [2];
   logic        ack_r  [2];
   logic        stray  [2];
   logic [1:0]  gnt    [2];

   logic [15:0] exp_q   [4][$];
   int          ack_log [2][$];
   int          ack_cyc [4];
   int          cyc_n = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] resp(input logic [18:0] a, input logic [15:0] d,
                                        input logic [1:0] s, input logic w);
      return a[15:0] ^ {a[18:16], 13'h0} ^ {d[7:0], d[15:8]} ^ {s, 14'h0} ^ {15'h0, w};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      wb_arb2 #(.RR(g == 1), .MAX_HOLD(4)) u_dut (
         .wb_clk_i (clk),
         .wb_rst_i (rst),
         .m0_adr_i (m_adr[2*g]),
         .m0_dat_i (m_dat[2*g]),
         .m0_sel_i (m_sel[2*g]),
         .m0_we_i  (m_we[2*g]),
         .m0_stb_i (m_stb[2*g]),
         .m0_cyc_i (m_cyc[2*g]),
         .m0_dat_o (m_rdat[2*g]),
         .m0_ack_o (m_ack[2*g]),
         .m1_adr_i (m_adr[2*g+1]),
         .m1_dat_i (m_dat[2*g+1]),
         .m1_sel_i (m_sel[2*g+1]),
         .m1_we_i  (m_we[2*g+1]),
         .m1_stb_i (m_stb[2*g+1]),
         .m1_cyc_i (m_cyc[2*g+1]),
         .m1_dat_o (m_rdat[2*g+1]),
         .m1_ack_o (m_ack[2*g+1]),
         .s_adr_o  (s_adr[g]),
         .s_dat_o  (s_wdat[g]),
         .s_sel_o  (s_sel[g]),
         .s_we_o   (s_we[g]),
         .s_stb_o  (s_stb[g]),
         .s_cyc_o  (s_cyc[g]),
         .s_dat_i  (s_rdat[g]),
         .s_ack_i  (s_ack[g]),
         .gnt_o    (gnt[g])
      );

      always @(posedge clk or posedge rst) begin
         if (rst) ack_r[g] <= 1'b0;
         else     ack_r[g] <= s_cyc[g] & s_stb[g] & !ack_r[g];
      end
      assign s_ack[g]  = ack_r[g] | stray[g];
      assign s_rdat[g] = resp(s_adr[g], s_wdat[g], s_sel[g], s_we[g]);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc_n++;
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (m_ack[k]) begin
               ack_cyc[k] = cyc_n;
               ack_log[k/2].push_back(k % 2);
               if (exp_q[k].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_ack master=%0d got=ack expected=none", k);
               end else begin
                  chk($sformatf("rdat_m%0d", k), 32'(m_rdat[k]), 32'(exp_q[k].pop_front()));
               end
            end
         end
      end
   end

   function automatic logic [31:0] enc(input int d);
      logic [31:0] v = '0;
      for (int i = 0; i < ack_log[d].size(); i++) v = (v << 4) | 32'(ack_log[d][i] + 1);
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; leaves the bus just after a rising edge.
   task automatic xfer(input int id, input logic [18:0] a, input int n, input int hold);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         m_adr[id] = a + 19'(i);
         m_dat[id] = 16'(m_adr[id][15:0] * 3) ^ 16'hC3C3;
         m_sel[id] = 2'(i + 1);
         m_we[id]  = i[0];
         m_cyc[id] = 1'b1;
         m_stb[id] = 1'b1;
         exp_q[id].push_back(resp(m_adr[id], m_dat[id], m_sel[id], m_we[id]));
         do begin
            @(negedge clk);
            t++;
         end while (!m_ack[id] && t < 200);
         if (!m_ack[id]) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout master=%0d got=no ack expected=ack", id);
            m_cyc[id] = 1'b0;
            m_stb[id] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      m_stb[id] = 1'b0;
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      m_cyc[id] = 1'b0;
   endtask

   // Single read on the fixed-priority instance with cycle-exact checks of latency and release.
   task automatic timed_single(input int id, input logic [18:0] a);
      logic [1:0] own = (id == 0) ? 2'b01 : 2'b10;
      m_adr[id] = a;
      m_dat[id] = 16'h0000;
      m_sel[id] = 2'b11;
      m_we[id]  = 1'b0;
      m_cyc[id] = 1'b1;
      m_stb[id] = 1'b1;
      exp_q[id].push_back(resp(a, 16'h0000, 2'b11, 1'b0));
      @(negedge clk);
      chk("lat_cycle0", 32'({gnt[0], s_stb[0]}), 32'({2'b00, 1'b0}));
      @(negedge clk);
      chk("lat_cycle1", 32'({gnt[0], s_stb[0], s_adr[0]}), 32'({own, 1'b1, a}));
      @(negedge clk);
      chk("ack_cycle2", 32'({m_ack[id], m_ack[1-id]}), 32'(2'b10));
      @(posedge clk);
      #1;
      m_cyc[id] = 1'b0;
      m_stb[id] = 1'b0;
      @(negedge clk);
      chk("release_edge", 32'(gnt[0]), 32'(own));
      @(negedge clk);
      chk("release_idle", 32'(gnt[0]), 32'(2'b00));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 4; k++) begin
         m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0;
         m_we[k] = 1'b0; m_stb[k] = 1'b0; m_cyc[k] = 1'b0;
         ack_cyc[k] = 0;
      end
      stray[0] = 1'b0;
      stray[1] = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_outs_a", 32'({gnt[0], s_cyc[0], s_stb[0], s_we[0], m_ack[0], m_ack[1]}), 32'h0);
      chk("rst_outs_b", 32'({gnt[1], s_cyc[1], s_stb[1], s_we[1], m_ack[2], m_ack[3]}), 32'h0);
      rst = 1'b0;
      idle(2);

      // single m1 read
      timed_single(1, 19'h12345);

      // stray slave ack while idle
      stray[0] = 1'b1;
      @(negedge clk);
      chk("stray_no_ack", 32'({m_ack[0], m_ack[1]}), 32'h0);
      @(posedge clk);
      #1;
      stray[0] = 1'b0;
      @(negedge clk);
      chk("stray_idle", 32'(gnt[0]), 32'h0);
      idle(1);

      // tie, fixed priority: m0 first, m1 follows with no idle cycle
      ack_log[0].delete();
      fork
         xfer(0, 19'h00100, 1, 0);
         xfer(1, 19'h00200, 1, 0);
      join
      chk("fp_tie_order", enc(0), 32'h12);
      chk("fp_tie_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
      idle(3);

      // round-robin: first tie goes to m0 (last resets to 1)
      ack_log[1].delete();
      fork
         xfer(2, 19'h00300, 1, 0);
         xfer(3, 19'h00400, 1, 0);
      join
      chk("rr_tie1_order", enc(1), 32'h12);
      chk("rr_tie1_gap", 32'(ack_cyc[3] - ack_cyc[2]), 32'd3);
      idle(3);
      xfer(2, 19'h00500, 1, 0);
      idle(3);
      ack_log[1].delete();
      fork
         xfer(2, 19'h00600, 1, 0);
         xfer(3, 19'h00700, 1, 0);
      join
      chk("rr_tie2_order", enc(1), 32'h21);
      chk("rr_tie2_gap", 32'(ack_cyc[2] - ack_cyc[3]), 32'd3);
      idle(3);

      // hold limit: 4 m0 acks, forced handoff to m1, then m0 regranted
      ack_log[0].delete();
      fork
         xfer(0, 19'h40000, 6, 0);
         xfer(1, 19'h7FFF0, 1, 0);
      join
      chk("hold_order", enc(0), 32'h1111211);
      idle(3);
      chk("hold_end_idle", 32'(gnt[0]), 32'h0);

      // m1 keeps cyc with stb low: ownership kept, hcnt stays 0
      fork
         xfer(1, 19'h01000, 1, 6);
         begin
            int t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!m_ack[1] && t < 50);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk($sformatf("keep_own_%0d", i),
                   32'({gnt[0], s_cyc[0], s_stb[0], gen_dut[0].u_dut.hcnt}),
                   32'({2'b10, 1'b1, 1'b0, 8'h00}));
            end
         end
      join
      idle(3);
      chk("keep_released", 32'(gnt[0]), 32'h0);

      // reset mid-transfer
      m_adr[0] = 19'h0ABCD;
      m_sel[0] = 2'b01;
      m_we[0]  = 1'b1;
      m_cyc[0] = 1'b1;
      m_stb[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_stb", 32'({gnt[0], s_stb[0], s_we[0]}), 32'({2'b01, 1'b1, 1'b1}));
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", 32'({gnt[0], s_cyc[0], s_stb[0], s_we[0], m_ack[0], m_ack[1]}), 32'h0);
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      m_we[0]  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      timed_single(0, 19'h05555);
      idle(2);

      for (int k = 0; k < 4; k++)
         chk($sformatf("queue_empty_m%0d", k), 32'(exp_q[k].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
